// File: rtl/alu_pkg.sv
// Shared constants and FSM encoding for the ALU command sequencer.
// Opcode set, load-select codes and default widths of the ALU top.
package alu_pkg;

  localparam int NB_DATA_DEF     = 6;
  localparam int NB_SEL_DEF      = 2;
  localparam int NB_RES_DEF      = 4;
  localparam int WAIT_CYCLES_DEF = 2;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  localparam logic [1:0] SEL_A  = 2'b00;
  localparam logic [1:0] SEL_B  = 2'b01;
  localparam logic [1:0] SEL_OP = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    LOAD_OP,
    WAIT,
    RESP
  } seq_state_e;

  function automatic logic is_legal_op(
    input logic [5:0] op
  );
    return op inside {
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR
    };
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Replays one host command as three strobed ALU loads, then returns
// the settled result. Optional opcode screening: ALU_SEQ_OPCODE_CHECK_EN.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int NB_DATA     = NB_DATA_DEF,
  parameter int NB_SEL      = NB_SEL_DEF,
  parameter int NB_RES      = NB_RES_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [NB_DATA-1:0] i_op_a,
  input  logic [NB_DATA-1:0] i_op_b,
  input  logic [NB_DATA-1:0] i_opcode,
  output logic [NB_DATA-1:0] o_dato,
  output logic [NB_SEL-1:0]  o_sw,
  output logic               o_load,
  input  logic [NB_RES-1:0]  i_result,
  output logic               o_res_valid,
  input  logic               i_res_ready,
  output logic [NB_RES-1:0]  o_result,
  output logic               o_err
);

  localparam int NB_CNT =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] CNT_LAST =
    NB_CNT'(WAIT_CYCLES - 1);

  seq_state_e state_q, state_d;

  logic              phase_q, phase_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;

  logic [NB_DATA-1:0] op_b_q, op_b_d;
  logic [NB_DATA-1:0] opc_q, opc_d;

  logic               cmd_ready_q, cmd_ready_d;
  logic               load_q, load_d;
  logic [NB_SEL-1:0]  sw_q, sw_d;
  logic [NB_DATA-1:0] dato_q, dato_d;
  logic               res_valid_q, res_valid_d;
  logic [NB_RES-1:0]  result_q, result_d;
  logic               err_q, err_d;

  logic accept;
  logic op_ok;

  assign accept = (state_q == IDLE)
                & cmd_ready_q
                & i_cmd_valid;

`ifdef ALU_SEQ_OPCODE_CHECK_EN
  assign op_ok = is_legal_op(6'(i_opcode));
`else
  assign op_ok = 1'b1;
`endif

  // Next-state, operand capture and result capture.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    op_b_d   = op_b_q;
    opc_d    = opc_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_b_d  = i_op_b;
          opc_d   = i_opcode;
          phase_d = 1'b0;
          cnt_d   = '0;
          if (op_ok) begin
            state_d = LOAD_A;
          end else begin
            state_d  = RESP;
            result_d = '0;
            err_d    = 1'b1;
          end
        end
      end
      LOAD_A: begin
        phase_d = ~phase_q;
        if (phase_q) state_d = LOAD_B;
      end
      LOAD_B: begin
        phase_d = ~phase_q;
        if (phase_q) state_d = LOAD_OP;
      end
      LOAD_OP: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = RESP;
          result_d = i_result;
          err_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (i_res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    load_d      = 1'b0;
    sw_d        = sw_q;
    dato_d      = dato_q;
    res_valid_d = (state_d == RESP);
    cmd_ready_d = (state_d == IDLE);
    unique case (1'b1)
      (state_d == LOAD_A): begin
        sw_d   = NB_SEL'(SEL_A);
        dato_d = (state_q == IDLE) ? i_op_a : dato_q;
        load_d = ~phase_d;
      end
      (state_d == LOAD_B): begin
        sw_d   = NB_SEL'(SEL_B);
        dato_d = op_b_q;
        load_d = ~phase_d;
      end
      (state_d == LOAD_OP): begin
        sw_d   = NB_SEL'(SEL_OP);
        dato_d = opc_q;
        load_d = ~phase_d;
      end
      default: ;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
      op_b_q      <= '0;
      opc_q       <= '0;
      cmd_ready_q <= 1'b0;
      load_q      <= 1'b0;
      sw_q        <= '0;
      dato_q      <= '0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      op_b_q      <= op_b_d;
      opc_q       <= opc_d;
      cmd_ready_q <= cmd_ready_d;
      load_q      <= load_d;
      sw_q        <= sw_d;
      dato_q      <= dato_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      err_q       <= err_d;
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_load      = load_q;
  assign o_sw        = sw_q;
  assign o_dato      = dato_q;
  assign o_res_valid = res_valid_q;
  assign o_result    = result_q;
  assign o_err       = err_q;

endmodule
